mem_stage: RTL and testbench

Memory-access stage placed directly downstream of the execute stage. It consumes the registered ALU result (used as the effective address or as a pass-through result), the buffered store data, and the buffered writeback address/immediate. It runs load/store transactions on a single-beat req/ack data-memory port and stalls upstream while a transaction is outstanding. It drives registered writeback signals to the writeback stage.

---
 rtl/mem_stage.sv | 196 +++++++++++++++++++
 tb/tb_mem_stage.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: load/store stage driving a single-beat req/ack data port.
// Define MEM_ALIGN_CHECK_EN to reject misaligned accesses with a misalign pulse.
module mem_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_in,
   input  logic [1:0]  mem_op,
   input  logic [1:0]  mem_size,
   input  logic        mem_unsigned,
   input  logic [63:0] alu_out,
   input  logic [63:0] mem_data,
   input  logic [4:0]  wb_addr_exec,
   input  logic [11:0] wb_imm_exec,
   output logic        stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [63:0] dmem_addr,
   output logic [63:0] dmem_wdata,
   output logic [7:0]  dmem_wstrb,
   input  logic        dmem_ack,
   input  logic [63:0] dmem_rdata,
   output logic        wb_valid,
   output logic [63:0] wb_data,
   output logic [4:0]  wb_addr_mem,
   output logic [11:0] wb_imm_mem,
   output logic        bus_err,
   output logic        misalign
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state;
   logic [7:0]  cnt;
   logic        r_load;
   logic [1:0]  r_size;
   logic        r_uns;
   logic [2:0]  r_off;

   logic        is_load;
   logic        is_store;
   logic        is_mem;
   logic        reject;
   logic [2:0]  off;
   logic [7:0]  size_mask;
   logic [7:0]  lane_strb;
   logic [63:0] lane_wdata;
   logic [63:0] shifted;
   logic [63:0] load_val;

   assign stall = (state == BUSY);
   assign off   = alu_out[2:0];

   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      unique case (1'b1)
         mem_op == 2'b01: is_load  = 1'b1;
         mem_op == 2'b10: is_store = 1'b1;
         default: ;
      endcase
      is_mem = is_load | is_store;
   end

   always_comb begin
      unique case (mem_size)
         2'b00:   size_mask = 8'h01;
         2'b01:   size_mask = 8'h03;
         2'b10:   size_mask = 8'h0F;
         default: size_mask = 8'hFF;
      endcase
      // Lanes past byte 7 fall off the top of the doubleword.
      lane_strb  = size_mask << off;
      lane_wdata = mem_data << {off, 3'b000};
   end

`ifdef MEM_ALIGN_CHECK_EN
   logic mis;

   always_comb begin
      unique case (mem_size)
         2'b00:   mis = 1'b0;
         2'b01:   mis = off[0];
         2'b10:   mis = |off[1:0];
         default: mis = |off;
      endcase
   end

   assign reject = is_mem & mis;
`else
   assign reject = 1'b0;
`endif

   always_comb begin
      shifted = dmem_rdata >> {r_off, 3'b000};
      unique case (r_size)
         2'b00: begin
            load_val = r_uns
               ? {56'b0, shifted[7:0]}
               : {{56{shifted[7]}}, shifted[7:0]};
         end
         2'b01: begin
            load_val = r_uns
               ? {48'b0, shifted[15:0]}
               : {{48{shifted[15]}}, shifted[15:0]};
         end
         2'b10: begin
            load_val = r_uns
               ? {32'b0, shifted[31:0]}
               : {{32{shifted[31]}}, shifted[31:0]};
         end
         default: load_val = shifted;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         r_load      <= 1'b0;
         r_size      <= '0;
         r_uns       <= 1'b0;
         r_off       <= '0;
         dmem_req    <= 1'b0;
         dmem_we     <= 1'b0;
         dmem_addr   <= '0;
         dmem_wdata  <= '0;
         dmem_wstrb  <= '0;
         wb_valid    <= 1'b0;
         wb_data     <= '0;
         wb_addr_mem <= '0;
         wb_imm_mem  <= '0;
         bus_err     <= 1'b0;
         misalign    <= 1'b0;
      end else begin
         wb_valid <= 1'b0;
         bus_err  <= 1'b0;
         misalign <= 1'b0;
         unique case (state)
            IDLE: begin
               if (valid_in) begin
                  if (reject) begin
                     misalign <= 1'b1;
                  end else if (is_mem) begin
                     r_load      <= is_load;
                     r_size      <= mem_size;
                     r_uns       <= mem_unsigned;
                     r_off       <= off;
                     wb_addr_mem <= wb_addr_exec;
                     wb_imm_mem  <= wb_imm_exec;
                     dmem_req    <= 1'b1;
                     dmem_we     <= is_store;
                     dmem_addr   <= {alu_out[63:3], 3'b000};
                     dmem_wdata  <= lane_wdata;
                     dmem_wstrb  <= lane_strb;
                     cnt         <= '0;
                     state       <= BUSY;
                  end else begin
                     wb_valid    <= 1'b1;
                     wb_data     <= alu_out;
                     wb_addr_mem <= wb_addr_exec;
                     wb_imm_mem  <= wb_imm_exec;
                  end
               end
            end
            BUSY: begin
               // An ack in the limit cycle still completes the transfer.
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  state    <= IDLE;
                  if (r_load) begin
                     wb_valid <= 1'b1;
                     wb_data  <= load_val;
                  end
               end else if (cnt == LAST) begin
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  bus_err  <= 1'b1;
                  state    <= IDLE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized bench for mem_stage against a transaction-level model.
// Build with MEM_ALIGN_CHECK_EN to match a DUT built with alignment checking.
module tb_mem_stage;

   localparam int TO = 4;

   typedef struct packed {
      logic        v;
      logic [1:0]  op;
      logic [1:0]  sz;
      logic        uns;
      logic [63:0] a;
      logic [63:0] d;
      logic [4:0]  ra;
      logic [11:0] imm;
   } ins_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in;
   logic [1:0]  mem_op;
   logic [1:0]  mem_size;
   logic        mem_unsigned;
   logic [63:0] alu_out;
   logic [63:0] mem_data;
   logic [4:0]  wb_addr_exec;
   logic [11:0] wb_imm_exec;
   logic        stall;
   logic        dmem_req;
   logic        dmem_we;
   logic [63:0] dmem_addr;
   logic [63:0] dmem_wdata;
   logic [7:0]  dmem_wstrb;
   logic        dmem_ack;
   logic [63:0] dmem_rdata;
   logic        wb_valid;
   logic [63:0] wb_data;
   logic [4:0]  wb_addr_mem;
   logic [11:0] wb_imm_mem;
   logic        bus_err;
   logic        misalign;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in),
      .mem_op(mem_op), .mem_size(mem_size),
      .mem_unsigned(mem_unsigned), .alu_out(alu_out),
      .mem_data(mem_data), .wb_addr_exec(wb_addr_exec),
      .wb_imm_exec(wb_imm_exec), .stall(stall),
      .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack),
      .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
      .wb_data(wb_data), .wb_addr_mem(wb_addr_mem),
      .wb_imm_mem(wb_imm_mem), .bus_err(bus_err),
      .misalign(misalign)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] sz);
      return 1 << sz;
   endfunction

   function automatic logic [7:0] m_strb(input logic [1:0] sz,
                                         input logic [2:0] off);
      logic [7:0] s = '0;
      for (int b = 0; b < 8; b++)
         if (b >= int'(off) && b < int'(off) + nbytes(sz)) s[b] = 1'b1;
      return s;
   endfunction

   function automatic logic [63:0] m_wdata(input logic [63:0] d,
                                           input logic [2:0] off);
      logic [63:0] w = '0;
      for (int b = 0; b < 8; b++)
         if (b >= int'(off)) w[8*b +: 8] = d[8*(b-int'(off)) +: 8];
      return w;
   endfunction

   function automatic logic [63:0] m_load(input logic [63:0] rd,
                                          input logic [1:0] sz,
                                          input logic [2:0] off,
                                          input logic uns);
      logic [63:0] v = '0;
      int n = nbytes(sz);
      for (int i = 0; i < n; i++)
         if (int'(off) + i < 8) v[8*i +: 8] = rd[8*(int'(off)+i) +: 8];
      if (!uns && v[8*n-1])
         for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
      return v;
   endfunction

   function automatic logic m_mis(input logic [1:0] sz,
                                  input logic [2:0] off);
      int n = nbytes(sz);
      return (int'(off) % n) != 0;
   endfunction

   task automatic drive(input ins_t t);
      valid_in     = t.v;
      mem_op       = t.op;
      mem_size     = t.sz;
      mem_unsigned = t.uns;
      alu_out      = t.a;
      mem_data     = t.d;
      wb_addr_exec = t.ra;
      wb_imm_exec  = t.imm;
   endtask

   function automatic ins_t gen();
      ins_t t;
      t.v   = ($urandom_range(0, 7) != 0);
      t.op  = 2'($urandom_range(0, 3));
      t.sz  = 2'($urandom_range(0, 3));
      t.uns = 1'($urandom_range(0, 1));
      t.a   = {32'($urandom), 32'($urandom)};
      t.d   = {32'($urandom), 32'($urandom)};
      t.ra  = 5'($urandom);
      t.imm = 12'($urandom);
      return t;
   endfunction

   // c is accepted at the next edge; n is presented while c is in flight.
   task automatic run(input ins_t c, input ins_t n, input int w,
                      input logic [63:0] rd);
      logic        mem;
      logic        mis;
      logic [63:0] ea;
      drive(c);
      dmem_ack   = ($urandom_range(0, 3) == 0);
      dmem_rdata = {32'($urandom), 32'($urandom)};
      mem = (c.op == 2'b01) || (c.op == 2'b10);
      mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      mis = m_mis(c.sz, c.a[2:0]);
`endif
      ea = c.a & ~64'h7;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      chk("misalign", misalign, c.v && mem && mis);
      if (!c.v || (mem && mis)) begin
         chk("idle_wbv", wb_valid, 0);
         chk("idle_req", dmem_req, 0);
         chk("idle_stall", stall, 0);
         return;
      end
      if (!mem) begin
         chk("pt_wbv", wb_valid, 1);
         chk("pt_data", wb_data, c.a);
         chk("pt_addr", wb_addr_mem, c.ra);
         chk("pt_imm", wb_imm_mem, c.imm);
         chk("pt_stall", stall, 0);
         chk("pt_req", dmem_req, 0);
         return;
      end
      chk("acc_req", dmem_req, 1);
      chk("acc_we", dmem_we, c.op == 2'b10);
      chk("acc_addr", dmem_addr, ea);
      chk("acc_strb", dmem_wstrb, m_strb(c.sz, c.a[2:0]));
      chk("acc_wdata", dmem_wdata, m_wdata(c.d, c.a[2:0]));
      chk("acc_stall", stall, 1);
      chk("acc_wbv", wb_valid, 0);
      drive(n);
      for (int k = 0; k < TO + 4; k++) begin
         dmem_ack   = (k == w);
         dmem_rdata = rd;
         @(posedge clk); #1;
         if (k == w) begin
            chk("ack_req", dmem_req, 0);
            chk("ack_stall", stall, 0);
            chk("ack_berr", bus_err, 0);
            chk("ack_wbv", wb_valid, c.op == 2'b01);
            if (c.op == 2'b01) begin
               chk("ld_data", wb_data,
                   m_load(rd, c.sz, c.a[2:0], c.uns));
               chk("ld_addr", wb_addr_mem, c.ra);
               chk("ld_imm", wb_imm_mem, c.imm);
            end
            break;
         end else if (k == TO - 1) begin
            chk("to_req", dmem_req, 0);
            chk("to_berr", bus_err, 1);
            chk("to_stall", stall, 0);
            chk("to_wbv", wb_valid, 0);
            break;
         end else begin
            chk("wt_req", dmem_req, 1);
            chk("wt_stall", stall, 1);
            chk("wt_addr", dmem_addr, ea);
            chk("wt_berr", bus_err, 0);
            chk("wt_wbv", wb_valid, 0);
         end
      end
      dmem_ack = 1'b0;
   endtask

   ins_t cur;
   ins_t nxt;
   ins_t idle_i;

   initial begin
      idle_i = '0;
      rst = 1'b1;
      drive(idle_i);
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req", dmem_req, 0);
      chk("rst_we", dmem_we, 0);
      chk("rst_stall", stall, 0);
      chk("rst_wbv", wb_valid, 0);
      chk("rst_wdata", wb_data, 0);
      chk("rst_addr", dmem_addr, 0);
      chk("rst_strb", dmem_wstrb, 0);
      chk("rst_berr", bus_err, 0);
      chk("rst_mis", misalign, 0);
      rst = 1'b0;

      cur = idle_i;
      cur.v = 1; cur.op = 2'b00; cur.a = 64'h1234; cur.ra = 5;
      run(cur, idle_i, 0, '0);
      chk("dir_pt", wb_data, 64'h1234);

      cur = idle_i;
      cur.v = 1; cur.op = 2'b01; cur.sz = 2'b00; cur.a = 64'h103;
      run(cur, idle_i, 2, 64'h00000000_80000000);
      chk("dir_sbyte", wb_data, 64'hFFFF_FFFF_FFFF_FF80);

      cur = idle_i;
      cur.v = 1; cur.op = 2'b10; cur.sz = 2'b10; cur.a = 64'h204;
      cur.d = 64'hAABBCCDD;
      run(cur, idle_i, 0, '0);

      cur = idle_i;
      cur.v = 1; cur.op = 2'b01; cur.sz = 2'b11; cur.a = 64'h300;
      run(cur, idle_i, 100, '0);
      @(posedge clk); #1;
      chk("berr_once", bus_err, 0);

      cur = idle_i;
      cur.v = 1; cur.op = 2'b01; cur.sz = 2'b11; cur.a = 64'h308;
      run(cur, idle_i, TO - 1, 64'h0123_4567_89AB_CDEF);
      chk("ack_wins", wb_data, 64'h0123_4567_89AB_CDEF);

      cur = idle_i;
      cur.v = 1; cur.op = 2'b01; cur.sz = 2'b01; cur.a = 64'h101;
      run(cur, idle_i, 0, 64'hFFFF_FFFF_FFFF_FFFF);

      // Reset in the second BUSY cycle, then a stale ack.
      cur = idle_i;
      cur.v = 1; cur.op = 2'b01; cur.sz = 2'b10; cur.a = 64'h400;
      drive(cur);
      @(posedge clk); #1;
      drive(idle_i);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rl_req", dmem_req, 0);
      chk("rl_stall", stall, 0);
      chk("rl_wbv", wb_valid, 0);
      dmem_ack   = 1'b1;
      dmem_rdata = 64'hDEAD;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      chk("rl_ack_wbv", wb_valid, 0);
      chk("rl_ack_req", dmem_req, 0);

      cur = gen();
      for (int i = 0; i < 400; i++) begin
         nxt = gen();
         run(cur, nxt, $urandom_range(0, TO + 1),
             {32'($urandom), 32'($urandom)});
         cur = nxt;
      end

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
